// File: rtl/keypair_stream_out_if.sv
// Byte-serial valid/ready stream carrying key bytes to the host.
interface keypair_stream_out_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tsel;
    logic       tlast;

    modport master (
        output tdata,
        output tvalid,
        output tsel,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tsel,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/keypair_stream_out.sv
// Snapshots the Dilithium key pair on keygen completion and streams it
// out byte-serially: public key first, then secret key.
module keypair_stream_out #(
    parameter int PK_BYTES = 1952,
    parameter int SK_BYTES = 4032
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    done_keygen,
    input  logic [8*PK_BYTES-1:0]   pk_in,
    input  logic [8*SK_BYTES-1:0]   sk_in,
    keypair_stream_out_if.master    m,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
);
    localparam int SNAP_BITS = 8 * (PK_BYTES + SK_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        SEND_PK,
        SEND_SK
    } state_t;

    state_t                 state_q;
    logic [12:0]            idx_q;
    logic                   done_prev_q;
    logic                   done_q;
    logic                   overrun_q;
    logic [SNAP_BITS-1:0]   snap_q;
    logic [SNAP_BITS-1:0]   snap_d;

    logic rise;
    logic xfer;
    logic pk_last;
    logic sk_last;
    logic in_sk;

    assign rise    = done_keygen & ~done_prev_q;
    assign busy    = (state_q != IDLE);
    assign xfer    = busy & m.tready;
    assign pk_last = (idx_q == 13'(PK_BYTES - 1));
    assign sk_last = (idx_q == 13'(SK_BYTES - 1));
    assign in_sk   = (state_q == SEND_SK);

    assign m.tvalid = busy;
    assign m.tdata  = busy ? snap_q[7:0] : 8'h00;
    assign m.tsel   = in_sk;
    assign m.tlast  = in_sk & sk_last;
    assign done     = done_q;
    assign overrun  = overrun_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            done_prev_q <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            done_prev_q <= done_keygen;
            done_q      <= 1'b0;
            if (rise && busy) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        idx_q   <= '0;
                        state_q <= SEND_PK;
                    end
                end
                SEND_PK: begin
                    if (xfer) begin
                        if (pk_last) begin
                            idx_q   <= '0;
                            state_q <= SEND_SK;
                        end else begin
                            idx_q <= idx_q + 13'd1;
                        end
                    end
                end
                SEND_SK: begin
                    if (xfer) begin
                        if (sk_last) begin
                            idx_q   <= '0;
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 13'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // pk sits in the low bytes, so shifting right walks pk then sk
    always_comb begin
        snap_d = snap_q;
        if (state_q == IDLE && rise) begin
            snap_d = {sk_in, pk_in};
        end else if (xfer) begin
            snap_d = snap_q >> 8;
        end
    end

    always_ff @(posedge clock) begin
        snap_q <= snap_d;
    end
endmodule

// File: tb/tb_keypair_stream_out.sv
// Randomized bench for keypair_stream_out against a byte-array model.
module tb_keypair_stream_out;
    localparam int PK  = 1952;
    localparam int SK  = 4032;
    localparam int TOT = PK + SK;

    logic            clock = 1'b0;
    logic            reset;
    logic            done_keygen;
    logic [8*PK-1:0] pk_in;
    logic [8*SK-1:0] sk_in;
    logic            busy;
    logic            done;
    logic            overrun;

    keypair_stream_out_if m_if ();

    keypair_stream_out #(
        .PK_BYTES(PK),
        .SK_BYTES(SK)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .done_keygen(done_keygen),
        .pk_in      (pk_in),
        .sk_in      (sk_in),
        .m          (m_if),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [7:0] pk_b [PK];
    logic [7:0] sk_b [SK];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_keys(input bit rnd);
        for (int i = 0; i < PK; i++)
            pk_b[i] = rnd ? 8'($urandom) : 8'(i % 256);
        for (int i = 0; i < SK; i++)
            sk_b[i] = rnd ? 8'($urandom) : 8'(255 - (i % 256));
        for (int i = 0; i < PK; i++) pk_in[8*i +: 8] = pk_b[i];
        for (int i = 0; i < SK; i++) sk_in[8*i +: 8] = sk_b[i];
    endtask

    // mode: 0 plain, 1 corrupt inputs after capture, 2 overrun pulse, 3 hold level
    task automatic drain(input bit rnd, input int mode, output int done_at);
        int cnt = 0;
        int n = 0;
        int bad = -1;
        int gap = 0;
        int stab = 0;
        int zero_bad = 0;
        int bhold = 0;
        int ov = 0;
        logic [9:0] bad_act = '0;
        logic [9:0] bad_exp = '0;
        logic [9:0] prev = '0;
        logic [9:0] cur;
        logic [9:0] expv;
        logic held = 1'b0;
        done_at = -1;
        m_if.tready = rnd ? 1'($urandom % 2) : 1'b1;
        while (cnt < 4 * TOT + 100 && done_at < 0) begin
            step();
            cnt++;
            cur = {m_if.tdata, m_if.tsel, m_if.tlast};
            if (done === 1'b1) begin
                done_at = cnt;
                if (m_if.tvalid !== 1'b0 || cur !== 10'd0 || busy !== 1'b0)
                    zero_bad++;
            end else if (m_if.tvalid !== 1'b1 || busy !== 1'b1) begin
                gap++;
            end else begin
                if (held && cur !== prev) stab++;
                if (n >= TOT) expv = 10'h3ff;
                else if (n < PK) expv = {pk_b[n], 1'b0, 1'b0};
                else expv = {sk_b[n-PK], 1'b1, (n == TOT - 1)};
                if (bad < 0 && cur !== expv) begin
                    bad = n;
                    bad_act = cur;
                    bad_exp = expv;
                end
                prev = cur;
            end
            if (mode != 3 && cnt == 1) done_keygen = 1'b0;
            if (mode == 1 && cnt == 1) begin
                pk_in = {PK{8'hAA}};
                sk_in = {SK{8'hAA}};
            end
            if (mode == 2) begin
                if (ov == 0 && n == PK + 100 && m_if.tvalid) begin
                    done_keygen = 1'b1;
                    ov = 1;
                end else if (ov == 1) begin
                    done_keygen = 1'b0;
                    ov = 2;
                end
            end
            if (rnd) begin
                if (n == PK - 1 && m_if.tvalid && bhold < 3) begin
                    m_if.tready = 1'b0;
                    bhold++;
                end else begin
                    m_if.tready = 1'($urandom % 2);
                end
            end else begin
                m_if.tready = 1'b1;
            end
            held = m_if.tvalid && !m_if.tready;
            if (m_if.tvalid && m_if.tready) n++;
        end
        checks++;
        if (n !== TOT) begin
            failures++;
            $display("FAIL byte_count got=%0d want=%0d", n, TOT);
        end
        checks++;
        if (bad !== -1) begin
            failures++;
            $display("FAIL stream_data idx=%0d got data=%h sel=%b last=%b want data=%h sel=%b last=%b",
                     bad, bad_act[9:2], bad_act[1], bad_act[0],
                     bad_exp[9:2], bad_exp[1], bad_exp[0]);
        end
        checks++;
        if (gap !== 0) begin
            failures++;
            $display("FAIL valid_gap got=%0d cycles want=0", gap);
        end
        checks++;
        if (zero_bad !== 0 || done_at < 0) begin
            failures++;
            $display("FAIL done_cycle_idle got bad=%0d done_at=%0d want bad=0 done seen",
                     zero_bad, done_at);
        end
        if (rnd) begin
            checks++;
            if (stab !== 0 || bhold !== 3) begin
                failures++;
                $display("FAIL hold_stable got unstable=%0d bnd_holds=%0d want 0 and 3",
                         stab, bhold);
            end
        end else begin
            checks++;
            if (done_at !== TOT + 1) begin
                failures++;
                $display("FAIL done_latency got=%0d want=%0d", done_at, TOT + 1);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        done_keygen = 1'b0;
        m_if.tready = 1'b0;
        pk_in = '0;
        sk_in = '0;
        repeat (3) step();
        checks++;
        if ({m_if.tvalid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL reset_valid got tvalid=%b busy=%b want 0 0", m_if.tvalid, busy);
        end
        checks++;
        if ({m_if.tdata, m_if.tsel, m_if.tlast} !== 10'd0) begin
            failures++;
            $display("FAIL reset_data got %h want 000", {m_if.tdata, m_if.tsel, m_if.tlast});
        end
        checks++;
        if ({done, overrun} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags got done=%b overrun=%b want 0 0", done, overrun);
        end
        reset = 1'b0;
        m_if.tready = 1'b1;
        repeat (2) step();
        checks++;
        if ({m_if.tvalid, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL idle_ready got %b want 000", {m_if.tvalid, busy, done});
        end
    endtask

    task automatic test_basic();
        int d;
        load_keys(1'b0);
        done_keygen = 1'b1;
        drain(1'b0, 0, d);
        step();
        checks++;
        if ({done, m_if.tvalid} !== 2'b00) begin
            failures++;
            $display("FAIL done_pulse_width got done=%b tvalid=%b want 0 0", done, m_if.tvalid);
        end
    endtask

    task automatic test_backpressure();
        int d;
        load_keys(1'b0);
        done_keygen = 1'b1;
        drain(1'b1, 0, d);
        step();
    endtask

    task automatic test_snapshot();
        int d;
        load_keys(1'b1);
        done_keygen = 1'b1;
        drain(1'b0, 1, d);
        step();
    endtask

    task automatic test_overrun();
        int d;
        load_keys(1'b1);
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_pre got=%b want=0", overrun);
        end
        done_keygen = 1'b1;
        drain(1'b1, 2, d);
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set got=%b want=1", overrun);
        end
        load_keys(1'b1);
        done_keygen = 1'b1;
        drain(1'b0, 0, d);
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky got=%b want=1", overrun);
        end
        step();
    endtask

    task automatic test_reset_midstream();
        int d;
        load_keys(1'b1);
        m_if.tready = 1'b1;
        done_keygen = 1'b1;
        repeat (501) step();
        checks++;
        if ({m_if.tvalid, m_if.tdata} !== {1'b1, pk_b[500]}) begin
            failures++;
            $display("FAIL midstream_byte got v=%b d=%h want v=1 d=%h",
                     m_if.tvalid, m_if.tdata, pk_b[500]);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({m_if.tvalid, busy, overrun, done} !== 4'b0000) begin
            failures++;
            $display("FAIL midstream_reset got tvalid/busy/overrun/done=%b want 0000",
                     {m_if.tvalid, busy, overrun, done});
        end
        reset = 1'b0;
        drain(1'b0, 0, d);
        step();
    endtask

    task automatic test_level_hold();
        int d;
        int extra = 0;
        load_keys(1'b1);
        done_keygen = 1'b1;
        drain(1'b0, 3, d);
        for (int c = d; c < 10000; c++) begin
            step();
            if (m_if.tvalid !== 1'b0 || busy !== 1'b0) extra++;
        end
        checks++;
        if (extra !== 0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL level_hold got extra_valid=%0d overrun=%b want 0 0", extra, overrun);
        end
        done_keygen = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_overrun();
        test_reset_midstream();
        test_level_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
